// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath.
// Sequences per-cycle strobes, stalls on mem_ready, traps memory timeouts, counts retired instructions.
module multicycle_control #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             illegal_op,
    output logic             bus_err
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ORI_EX  = 4'd10,
        S_IWB     = 4'd11,
        S_JUMP    = 4'd12,
        S_JAL     = 4'd13,
        S_ERROR   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int               WAIT_W     = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam bit               TIMEOUT_EN = (MAX_WAIT != 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              illegal_op_q, illegal_op_d;
    logic              stall;
    logic              retiring;

    // State register plus bookkeeping flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            retire_cnt_q <= '0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        illegal_op_d = 1'b0;
        stall        = 1'b0;
        retiring     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           stall   = 1'b1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                // An opcode that changed away from lw/sw here is dropped without retiring
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
                else           stall   = 1'b1;
            end
            S_MEMWR: begin
                retiring = 1'b1;
                if (mem_ready) state_d = S_FETCH;
                else           stall   = 1'b1;
            end
            S_MEMWB:   begin state_d = S_FETCH; retiring = 1'b1; end
            S_EXEC:    state_d = S_RWB;
            S_RWB:     begin state_d = S_FETCH; retiring = 1'b1; end
            S_BRANCH:  begin state_d = S_FETCH; retiring = 1'b1; end
            S_ADDI_EX: state_d = S_IWB;
            S_ORI_EX:  state_d = S_IWB;
            S_IWB:     begin state_d = S_FETCH; retiring = 1'b1; end
            S_JUMP:    begin state_d = S_FETCH; retiring = 1'b1; end
            S_JAL:     begin state_d = S_FETCH; retiring = 1'b1; end
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_FETCH;
        endcase
        // A ready on the last tolerated cycle still completes normally
        if (TIMEOUT_EN && stall && (wait_cnt_q == WAIT_LAST)) state_d = S_ERROR;
    end

    always_comb begin
        if (state_d != state_q) wait_cnt_d = '0;
        else if (stall)         wait_cnt_d = wait_cnt_q + 1'b1;
        else                    wait_cnt_d = '0;
        retire_cnt_d = retire_cnt_q;
        if (retiring && (state_d == S_FETCH)) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end

    // Output logic (Moore, except the FETCH write enables)
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        bus_err     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; end
            S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
            S_EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            S_RWB:    begin RegWrite = 1'b1; RegDst = 2'b01; end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_ADDI_EX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_ORI_EX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b11; end
            S_IWB:     RegWrite = 1'b1;
            S_JUMP:    begin PCWrite = 1'b1; PCSource = 2'b10; end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            S_ERROR: bus_err = 1'b1;
            default: ;
        endcase
    end

    assign state      = state_q;
    assign retire_cnt = retire_cnt_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model queues per-cycle expectations,
// a monitor pops and compares every cycle.
module tb_multicycle_control;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]       RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal_op, bus_err;
    logic [19:0]      act;

    multicycle_control #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .retire_cnt(retire_cnt),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, illegal_op, bus_err};

    logic [19:0]      exp_q[$];
    logic [CNT_W-1:0] exp_rc_q[$];
    string            ph_q[$];
    int               n_tests = 0;
    int               n_fail = 0;
    int               exp_retire = 0;
    bit               exp_illegal = 1'b0;
    int               cycle = 0;

    // Expected strobes for one cycle of a named instruction phase
    function automatic logic [19:0] phase_vec(input string ph, input logic mr, input bit ill);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, asa = 0, bus = 0;
        logic [1:0] rdst = 0, m2r = 0, asb = 0, aop = 0, pcs = 0;
        case (ph)
            "F":   begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            "D":   asb = 2'b11;
            "MA":  begin asa = 1; asb = 2'b10; end
            "MR":  begin mrd = 1; iord = 1; end
            "MWB": begin rw = 1; m2r = 2'b01; end
            "MW":  begin mwr = 1; iord = 1; end
            "EX":  begin asa = 1; aop = 2'b10; end
            "RWB": begin rw = 1; rdst = 2'b01; end
            "BR":  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            "AE":  begin asa = 1; asb = 2'b10; end
            "OE":  begin asa = 1; asb = 2'b10; aop = 2'b11; end
            "IWB": rw = 1;
            "J":   begin pcw = 1; pcs = 2'b10; end
            "JAL": begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
            "ERR": bus = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, rdst, m2r, asb, aop, pcs, ill, bus};
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input string ph, input logic mr, input logic [5:0] op, input bit in_rst);
        @(negedge clk);
        rst_n     = ~in_rst;
        mem_ready = mr;
        opcode    = op;
        if (in_rst) begin
            exp_retire  = 0;
            exp_illegal = 1'b0;
        end
        exp_q.push_back(phase_vec(ph, mr, exp_illegal));
        exp_rc_q.push_back(CNT_W'(exp_retire));
        ph_q.push_back(ph);
        exp_illegal = 1'b0;
        cycle++;
    endtask

    task automatic do_reset();
        step("F", rnd_bit(), rnd_op(), 1'b1);
        step("F", rnd_bit(), rnd_op(), 1'b1);
        $display("[TB] reset");
    endtask

    task automatic mem_phase(input string ph, input int stalls);
        for (int i = 0; i < stalls; i++) step(ph, 1'b0, rnd_op(), 1'b0);
        step(ph, 1'b1, rnd_op(), 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        int  c0 = cycle;
        bit  legal = 1'b1;
        mem_phase("F", fs);
        step("D", rnd_bit(), op, 1'b0);
        case (op)
            6'd35: begin step("MA", rnd_bit(), op, 1'b0); mem_phase("MR", ms); step("MWB", rnd_bit(), rnd_op(), 1'b0); end
            6'd43: begin step("MA", rnd_bit(), op, 1'b0); mem_phase("MW", ms); end
            6'd0:  begin step("EX", rnd_bit(), rnd_op(), 1'b0); step("RWB", rnd_bit(), rnd_op(), 1'b0); end
            6'd4:  step("BR", rnd_bit(), rnd_op(), 1'b0);
            6'd8:  begin step("AE", rnd_bit(), rnd_op(), 1'b0); step("IWB", rnd_bit(), rnd_op(), 1'b0); end
            6'd13: begin step("OE", rnd_bit(), rnd_op(), 1'b0); step("IWB", rnd_bit(), rnd_op(), 1'b0); end
            6'd2:  step("J", rnd_bit(), rnd_op(), 1'b0);
            6'd3:  step("JAL", rnd_bit(), rnd_op(), 1'b0);
            default: begin legal = 1'b0; exp_illegal = 1'b1; end
        endcase
        if (legal) exp_retire = (exp_retire + 1) % (1 << CNT_W);
        $display("[TB] instr opcode=%0d fetch_stalls=%0d mem_stalls=%0d cycles=%0d", op, fs, ms, cycle - c0);
    endtask

    task automatic err_hold(input int n);
        for (int i = 0; i < n; i++) step("ERR", rnd_bit(), rnd_op(), 1'b0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle
    initial begin
        logic [19:0]      e;
        logic [CNT_W-1:0] rc;
        string            p;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                rc = exp_rc_q.pop_front();
                p  = ph_q.pop_front();
                n_tests++;
                if (act !== e || retire_cnt !== rc) begin
                    n_fail++;
                    $display("FAIL %s: got strobes=%b retire=%0d, want strobes=%b retire=%0d",
                             p, act, retire_cnt, e, rc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] legal_ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd13, 6'd2, 6'd3};
        logic [5:0] op;
        do_reset();
        run_instr(6'd0, 0, 0);
        run_instr(6'd35, 0, 3);
        run_instr(6'd3, 0, 0);
        run_instr(6'd63, 0, 0);
        run_instr(6'd43, 2, 3);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = rnd_op();
                while (op == 0 || op == 2 || op == 3 || op == 4 || op == 8 || op == 13 || op == 35 || op == 43);
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            run_instr(op, $urandom_range(0, MAX_WAIT - 1), $urandom_range(0, MAX_WAIT - 1));
        end
        // Memory read timeout
        step("F", 1'b1, rnd_op(), 1'b0);
        step("D", rnd_bit(), 6'd35, 1'b0);
        step("MA", rnd_bit(), 6'd35, 1'b0);
        for (int i = 0; i < MAX_WAIT; i++) step("MR", 1'b0, rnd_op(), 1'b0);
        err_hold(10);
        $display("[TB] lw timeout -> ERROR");
        do_reset();
        // Fetch timeout
        for (int i = 0; i < MAX_WAIT; i++) step("F", 1'b0, rnd_op(), 1'b0);
        err_hold(10);
        $display("[TB] fetch timeout -> ERROR");
        do_reset();
        // Retire counter wrap
        for (int i = 0; i < 16; i++) run_instr(6'd2, 0, 0);
        step("F", 1'b0, rnd_op(), 1'b0);
        // Reset during MEMADR aborts the load
        run_instr(6'd8, 0, 0);
        step("F", 1'b1, rnd_op(), 1'b0);
        step("D", rnd_bit(), 6'd35, 1'b0);
        step("F", rnd_bit(), 6'd35, 1'b1);
        $display("[TB] reset during MEMADR");
        step("F", 1'b0, rnd_op(), 1'b0);
        run_instr(6'd4, 1, 0);
        step("F", 1'b0, rnd_op(), 1'b0);
        @(negedge clk);
        #4;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath: one memory port for instruction and data, one ALU, and IR/MDR/A/B/ALUOut registers.
- Decodes the opcode set R-type(0), lw(35), sw(43), beq(4), addi(8), ori(13), j(2), jal(3) into per-cycle control strobes.
- Stalls on a memory-ready handshake, detects memory timeouts, and counts retired instructions.

Parameters:
- CNT_W, 32: width of retire_cnt.
- MAX_WAIT, 16: stall cycles tolerated on mem_ready before the FSM enters ERROR; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath strobes.
- RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  write-data select: 00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB  out  2  ALU B select: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUOp  out  2  ALU op: 00 add, 01 sub, 10 funct, 11 or.
- PCSource  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding, for debug.
- retire_cnt  out  CNT_W  count of retired instructions.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  high while in ERROR.

Behaviour:
- Outputs are combinational from state only. Exceptions: IRWrite and PCWrite in FETCH are qualified with mem_ready. Every signal not listed for a state is 0; no X values are ever driven.
- Reset (async, rst_n=0): state=FETCH, wait_cnt=0, retire_cnt=0, illegal_op=0. Outputs show FETCH values: MemRead=1, ALUSrcB=01, all others 0, IRWrite=PCWrite=mem_ready.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. If mem_ready -> DECODE, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 35 or 43 -> MEMADR; 0 -> EXEC; 4 -> BRANCH; 8 -> ADDI_EX; 13 -> ORI_EX; 2 -> JUMP; 3 -> JAL.
  - Any other opcode -> FETCH with illegal_op=1 for one cycle (registered; visible the cycle FETCH is entered).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Opcode 35 -> MEMRD, 43 -> MEMWR.
- MEMRD: MemRead=1, IorD=1. If mem_ready -> MEMWB, else stay.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. If mem_ready -> FETCH, else stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IWB. ORI_EX: same but ALUOp=11 -> IWB. Zero-extension for ori is the datapath's responsibility.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH. The link value is the PC+4 already written in FETCH.
- ERROR: all strobes 0, bus_err=1. Held until rst_n is asserted.
- Timeout:
  - wait_cnt increments each cycle in FETCH, MEMRD or MEMWR with mem_ready=0, and clears on any state change.
  - When MAX_WAIT!=0 and wait_cnt==MAX_WAIT-1 with mem_ready still 0, next state is ERROR.
  - mem_ready=1 on that same cycle wins: normal transition, no error.
- retire_cnt:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, IWB, JUMP or JAL.
  - Does not increment on the illegal-opcode return. Wraps modulo 2^CNT_W.
- Latency with zero-wait memory: lw 5 cycles; R-type, sw, addi, ori 4; beq, j, jal 3.
- opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Reset asserted mid-instruction aborts it immediately; the instruction is not counted.

Test Plan:
- Reset, then mem_ready=1, opcode=0 -> states FETCH, DECODE, EXEC, RWB, FETCH; RegWrite=1, RegDst=01 only in RWB; retire_cnt=1.
- opcode=35, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemtoReg=01; total 8 cycles; no bus_err.
- opcode=3 -> JAL asserts PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 in one cycle; retire_cnt increments.
- opcode=63 -> DECODE -> FETCH, illegal_op pulses once, retire_cnt unchanged.
- MAX_WAIT=4, mem_ready=0 in FETCH -> ERROR after 4 cycles, bus_err=1, all strobes 0. Held through 10 further cycles; rst_n low -> FETCH, bus_err=0.
- CNT_W=4, 16 back-to-back j instructions -> retire_cnt wraps to 0. A separate run with rst_n pulsed low during MEMADR -> immediate FETCH, retire_cnt=0.
